pipeline_ctrl: RTL and testbench

Sequencing controller for the 5-stage MIPS pipeline. Merges debug-unit run/step/pause commands, the decoded HALT instruction, and the hazard unit's `stall`/`flush_idex` requests into one set of per-stage write enables and flushes. Owns the global run state machine, drains the back end after HALT, and counts executed cycles.

---
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: merges debug commands, HALT and hazards
// into per-stage enables. Optional cycle counter enabled by PIPE_CTRL_CYCLE_COUNTER_EN.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        halt_instr,
  input  logic        hazard_stall,
  input  logic        hazard_flush,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic        step_done,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] drain_q, drain_d;
  logic       advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    advance     = 1'b0;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b0;
    halted      = 1'b0;
    step_done   = 1'b0;

    case (state_q)
      StIdle: begin
        // halt_req wins over step/run and simply keeps the core paused
        if (halt_req) begin
          state_d = StIdle;
        end else if (step_req) begin
          state_d = StStep;
        end else if (run_req) begin
          state_d = StRun;
        end
      end
      StRun: begin
        advance = 1'b1;
        if (halt_instr) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end else if (halt_req) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        advance   = 1'b1;
        step_done = 1'b1;
        if (halt_instr) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Front end frozen and bubbles injected while EX/MEM/WB empty out
        id_ex_flush = 1'b1;
        pipe_en     = 1'b1;
        if (drain_q <= 4'd1) begin
          state_d = StHalted;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
        drain_d = '0;
      end
    endcase

    if (advance) begin
      pipe_en = 1'b1;
      // Hazards dominate a taken branch; the branch is re-resolved once the stall clears
      if (hazard_stall || hazard_flush) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = branch_taken;
      end
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
    end else if (pipe_en) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: per-cycle expected outputs go through a scoreboard queue
// and are checked with immediate assertions.
module tb_pipeline_ctrl;

  localparam int unsigned Drain = 4;

  // Input vector bits: {run, step, halt_req, halt_instr, stall, flush, branch}
  localparam logic [6:0] INone  = 7'b0000000;
  localparam logic [6:0] IRun   = 7'b1000000;
  localparam logic [6:0] IStep  = 7'b0100000;
  localparam logic [6:0] IHreq  = 7'b0010000;
  localparam logic [6:0] IHins  = 7'b0001000;
  localparam logic [6:0] IStall = 7'b0000100;
  localparam logic [6:0] IFlush = 7'b0000010;
  localparam logic [6:0] IBr    = 7'b0000001;

  // Expected vector: {state[2:0], pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_en, halted,
  // step_done}
  localparam logic [9:0] EIdle   = {3'd0, 7'b0000000};
  localparam logic [9:0] ERunGo  = {3'd1, 7'b1100100};
  localparam logic [9:0] ERunBr  = {3'd1, 7'b1110100};
  localparam logic [9:0] ERunSt  = {3'd1, 7'b0001100};
  localparam logic [9:0] EStepGo = {3'd2, 7'b1100101};
  localparam logic [9:0] EStepSt = {3'd2, 7'b0001101};
  localparam logic [9:0] EDrain  = {3'd3, 7'b0001100};
  localparam logic [9:0] EHalt   = {3'd4, 7'b0000010};

  typedef struct {
    string       tag;
    logic [9:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req, step_req, halt_req, halt_instr;
  logic        hazard_stall, hazard_flush, branch_taken;
  logic        pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_en;
  logic [2:0]  state;
  logic        halted, step_done;
  logic [31:0] cycle_count;

  exp_t        sb[$];
  int          passes = 0;
  int          total = 0;
  logic [31:0] model_cnt = '0;

  pipeline_ctrl #(
    .DRAIN_CYCLES(Drain)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .halt_instr  (halt_instr),
    .hazard_stall(hazard_stall),
    .hazard_flush(hazard_flush),
    .branch_taken(branch_taken),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .pipe_en     (pipe_en),
    .state       (state),
    .halted      (halted),
    .step_done   (step_done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // One clock: drive at the falling edge, check mid-low phase, advance the count model at
  // the rising edge.
  task automatic cyc(input string tag, input logic [6:0] in, input logic [9:0] ctl);
    exp_t e;
    logic [9:0] obs;
    {run_req, step_req, halt_req, halt_instr, hazard_stall, hazard_flush, branch_taken} = in;
`ifdef PIPE_CTRL_CYCLE_COUNTER_EN
    sb.push_back('{tag: tag, ctl: ctl, cnt: model_cnt});
`else
    sb.push_back('{tag: tag, ctl: ctl, cnt: 32'd0});
`endif
    #2;
    e = sb.pop_front();
    obs = {state, pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_en, halted, step_done};
    total++;
    assert (obs === e.ctl) passes++;
    else $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    total++;
    assert (cycle_count === e.cnt) passes++;
    else $error("FAIL %s cycle_count observed=%0d expected=%0d", e.tag, cycle_count, e.cnt);
    @(posedge clk);
    if (!rst_n) model_cnt = '0;
    else if (ctl[2]) model_cnt = model_cnt + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {run_req, step_req, halt_req, halt_instr, hazard_stall, hazard_flush, branch_taken} = INone;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_cnt = '0;

    // Reset holds IDLE even with a run request present
    cyc("rst_hold", IRun, EIdle);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("idle", INone, EIdle);
    cyc("idle_hreq", IHreq, EIdle);
    cyc("idle_prio", IHreq | IStep, EIdle);
    cyc("idle_prio_after", INone, EIdle);

    // Continuous run with stall, flush+branch, branch, ignored requests, pause
    cyc("run_req", IRun, EIdle);
    cyc("run", INone, ERunGo);
    cyc("stall", IStall, ERunSt);
    cyc("unstall", INone, ERunGo);
    cyc("flush_br", IFlush | IBr, ERunSt);
    cyc("br", IBr, ERunBr);
    cyc("run_ign", IStep | IRun, ERunGo);
    cyc("halt_req", IHreq, ERunGo);
    cyc("paused", INone, EIdle);

    // Three single steps, four cycles apart
    for (int i = 0; i < 3; i++) begin
      cyc("step_req", IStep, EIdle);
      cyc("step", INone, EStepGo);
      cyc("step_idle", INone, EIdle);
      cyc("step_gap", INone, EIdle);
    end
    cyc("step_req2", IStep, EIdle);
    cyc("step_stall", IStall, EStepSt);
    cyc("step_stall_idle", INone, EIdle);

    // HALT in RUN: drain then halted; debug requests ignored throughout
    cyc("run2_req", IRun, EIdle);
    cyc("run2", INone, ERunGo);
    cyc("halt_instr", IHins | IHreq, ERunGo);
    cyc("drain0", IRun | IStall | IBr, EDrain);
    for (int i = 1; i < Drain; i++) cyc("drain", IHreq, EDrain);
    cyc("halted", IRun, EHalt);
    cyc("halted_step", IStep, EHalt);
    cyc("halted_hold", INone, EHalt);

    // Reset mid-drain: clean restart, counter cleared
    rst_n = 1'b0;
    cyc("rst_in_halt", INone, EHalt);
    rst_n = 1'b1;
    cyc("run3_req", IRun, EIdle);
    cyc("run3", INone, ERunGo);
    cyc("halt_instr3", IHins, ERunGo);
    cyc("drain3a", INone, EDrain);
    cyc("drain3b", INone, EDrain);
    rst_n = 1'b0;
    cyc("rst_mid_drain", INone, EDrain);
    rst_n = 1'b1;
    cyc("post_rst", INone, EIdle);
    cyc("run4_req", IRun, EIdle);
    cyc("run4", INone, ERunGo);
    cyc("run4b", INone, ERunGo);

    // Reset mid-run, then HALT during a single step
    rst_n = 1'b0;
    cyc("rst_mid_run", INone, ERunGo);
    rst_n = 1'b1;
    cyc("step5_req", IStep, EIdle);
    cyc("step_hins", IHins, EStepGo);
    for (int i = 0; i < Drain; i++) cyc("drain5", IStep, EDrain);
    cyc("halted5", IRun, EHalt);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
